// File: rtl/m_board_commit.sv
// +----------------------------------------------------------------------------+
// | m_board_commit: Connect-Four board keeper (drop, win check, draw detect).  |
// | Optional macro WIN_CHECK_EN adds four-in-a-row detection.   Rev 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module m_board_commit #(
  parameter int FIRST_IS_ME            = 1,
  parameter int COL_SIZE               = 3,
  parameter int FIELD_SIZE             = 42,
  parameter int PILED_COUNT_ARRAY_SIZE = 21
) (
  input  logic                              w_clk,
  input  logic                              w_rst,
  input  logic                              i_clear,
  input  logic                              i_move_valid,
  input  logic [COL_SIZE-1:0]               i_move_col,
  output logic                              o_ready,
  output logic                              o_done,
  output logic                              o_illegal,
  output logic [FIELD_SIZE-1:0]             o_me_field,
  output logic [FIELD_SIZE-1:0]             o_op_field,
  output logic [PILED_COUNT_ARRAY_SIZE-1:0] o_piled_array,
  output logic                              o_turn_me,
  output logic                              o_win_me,
  output logic                              o_win_op,
  output logic                              o_draw,
  output logic [5:0]                        o_move_count
);

  localparam int C_COLS = 7;
  localparam int C_ROWS = 6;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLACE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
`ifdef WIN_CHECK_EN
  localparam logic [1:0] S_CHECK = 2'd3;
`endif

  logic [1:0]                        r_state;
  logic [1:0]                        w_state_nxt;
  logic [FIELD_SIZE-1:0]             r_me;
  logic [FIELD_SIZE-1:0]             r_op;
  logic [PILED_COUNT_ARRAY_SIZE-1:0] r_piled;
  logic                              r_turn;
  logic [5:0]                        r_count;
  logic                              r_draw;
  logic [COL_SIZE-1:0]               r_col;
  logic                              r_mover_me;
  logic                              r_illegal;

  logic                              w_accept;
  logic                              w_game_over;
  logic [2:0]                        w_height;
  logic                              w_illegal;
  logic [5:0]                        w_cell_idx;
  logic [FIELD_SIZE-1:0]             w_mask;

`ifdef WIN_CHECK_EN
  logic                              r_win_me;
  logic                              r_win_op;
  logic                              r_win_pend;
  logic [1:0]                        r_dir;
  logic [2:0]                        r_row;
  logic [FIELD_SIZE-1:0]             w_mover_field;
  int                                w_dr;
  int                                w_dc;
  int                                w_run;
  logic                              w_go_p;
  logic                              w_go_n;
  logic                              w_hit;

  // Off-board cells read as empty so runs stop at the edges.
  function automatic logic f_cell(input logic [FIELD_SIZE-1:0] f, input int r, input int c);
    logic v;
    v = 1'b0;
    if (r >= 0 && r < C_ROWS && c >= 0 && c < C_COLS)
      v = f[6'(r * C_COLS + c)];
    return v;
  endfunction

  assign w_mover_field = r_mover_me ? r_me : r_op;

  always_comb begin
    w_dr = 0;
    w_dc = 1;
    case (r_dir)
      2'd0:    begin w_dr = 0; w_dc = 1;  end
      2'd1:    begin w_dr = 1; w_dc = 0;  end
      2'd2:    begin w_dr = 1; w_dc = 1;  end
      default: begin w_dr = 1; w_dc = -1; end
    endcase
    w_run  = 0;
    w_go_p = 1'b1;
    w_go_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if (w_go_p && f_cell(w_mover_field, int'(r_row) + k * w_dr, int'(r_col) + k * w_dc))
        w_run = w_run + 1;
      else
        w_go_p = 1'b0;
      if (w_go_n && f_cell(w_mover_field, int'(r_row) - k * w_dr, int'(r_col) - k * w_dc))
        w_run = w_run + 1;
      else
        w_go_n = 1'b0;
    end
    w_hit = (w_run >= 3);
  end

  assign o_win_me = r_win_me;
  assign o_win_op = r_win_op;
`else
  assign o_win_me = 1'b0;
  assign o_win_op = 1'b0;
`endif

  assign w_game_over = o_win_me | o_win_op | r_draw;
  assign w_accept    = i_move_valid & o_ready;

  always_comb begin
    w_height = 3'd0;
    for (int c = 0; c < C_COLS; c++)
      if (r_col == COL_SIZE'(c)) w_height = r_piled[c*3 +: 3];
  end

  assign w_illegal  = (r_col >= COL_SIZE'(C_COLS)) || (w_height == 3'd6);
  assign w_cell_idx = {3'b000, w_height} * 6'd7 + 6'(r_col);
  assign w_mask     = {{(FIELD_SIZE-1){1'b0}}, 1'b1} << w_cell_idx;

  // State register
  always_ff @(posedge w_clk) begin
    if (w_rst || i_clear) r_state <= S_IDLE;
    else                  r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_PLACE;
`ifdef WIN_CHECK_EN
      S_PLACE: w_state_nxt = w_illegal ? S_DONE : S_CHECK;
      S_CHECK: if (r_dir == 2'd3) w_state_nxt = S_DONE;
`else
      S_PLACE: w_state_nxt = S_DONE;
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_ready   = 1'b0;
    o_done    = 1'b0;
    o_illegal = 1'b0;
    case (r_state)
      S_IDLE:  o_ready = !w_game_over;
      S_DONE:  begin o_done = 1'b1; o_illegal = r_illegal; end
      default: ;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst || i_clear) begin
      r_me       <= '0;
      r_op       <= '0;
      r_piled    <= '0;
      r_turn     <= (FIRST_IS_ME != 0);
      r_count    <= 6'd0;
      r_draw     <= 1'b0;
      r_col      <= '0;
      r_mover_me <= 1'b0;
      r_illegal  <= 1'b0;
`ifdef WIN_CHECK_EN
      r_win_me   <= 1'b0;
      r_win_op   <= 1'b0;
      r_win_pend <= 1'b0;
      r_dir      <= 2'd0;
      r_row      <= 3'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_col      <= i_move_col;
            r_mover_me <= r_turn;
`ifdef WIN_CHECK_EN
            r_win_pend <= 1'b0;
`endif
          end
        end
        S_PLACE: begin
          r_illegal <= w_illegal;
          if (!w_illegal) begin
            if (r_mover_me) r_me <= r_me | w_mask;
            else            r_op <= r_op | w_mask;
            for (int c = 0; c < C_COLS; c++)
              if (r_col == COL_SIZE'(c)) r_piled[c*3 +: 3] <= w_height + 3'd1;
            r_count <= r_count + 6'd1;
            r_turn  <= ~r_turn;
`ifdef WIN_CHECK_EN
            r_row   <= w_height;
            r_dir   <= 2'd0;
`endif
          end
        end
`ifdef WIN_CHECK_EN
        S_CHECK: begin
          r_dir <= r_dir + 2'd1;
          // Flags commit on the last direction so they appear together with o_done.
          if (r_dir == 2'd3) begin
            if (r_win_pend || w_hit) begin
              if (r_mover_me) r_win_me <= 1'b1;
              else            r_win_op <= 1'b1;
            end
          end else if (w_hit) begin
            r_win_pend <= 1'b1;
          end
        end
        S_DONE: begin
          if (r_count == 6'd42 && !r_win_me && !r_win_op) r_draw <= 1'b1;
        end
`else
        S_DONE: begin
          if (r_count == 6'd42) r_draw <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign o_me_field    = r_me;
  assign o_op_field    = r_op;
  assign o_piled_array = r_piled;
  assign o_turn_me     = r_turn;
  assign o_draw        = r_draw;
  assign o_move_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_m_board_commit.sv
// +----------------------------------------------------------------------------+
// | tb_m_board_commit: directed self-checking bench for m_board_commit.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_m_board_commit;

`ifdef WIN_CHECK_EN
  localparam int C_LAT = 5;
  localparam logic C_WIN = 1'b1;
`else
  localparam int C_LAT = 1;
  localparam logic C_WIN = 1'b0;
`endif

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic        i_clear;
  logic        i_move_valid;
  logic [2:0]  i_move_col;
  logic        o_ready;
  logic        o_done;
  logic        o_illegal;
  logic [41:0] o_me_field;
  logic [41:0] o_op_field;
  logic [20:0] o_piled_array;
  logic        o_turn_me;
  logic        o_win_me;
  logic        o_win_op;
  logic        o_draw;
  logic [5:0]  o_move_count;

  int n_checks = 0;
  int n_fail   = 0;

  m_board_commit u_dut (
    .w_clk         (w_clk),
    .w_rst         (w_rst),
    .i_clear       (i_clear),
    .i_move_valid  (i_move_valid),
    .i_move_col    (i_move_col),
    .o_ready       (o_ready),
    .o_done        (o_done),
    .o_illegal     (o_illegal),
    .o_me_field    (o_me_field),
    .o_op_field    (o_op_field),
    .o_piled_array (o_piled_array),
    .o_turn_me     (o_turn_me),
    .o_win_me      (o_win_me),
    .o_win_op      (o_win_op),
    .o_draw        (o_draw),
    .o_move_count  (o_move_count)
  );

  always #5 w_clk = ~w_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
  endtask

  // Handshake, then count edges until o_done; returns one cycle later (back in IDLE).
  task automatic do_move(input logic [2:0] col, output int lat, output logic ill,
                         output logic wm, output logic wo);
    int w;
    lat = -1; ill = 1'b0; wm = 1'b0; wo = 1'b0;
    w = 0;
    while (!o_ready && w < 20) begin step(); w++; end
    if (w >= 20) check("ready_timeout", {63'd0, o_ready}, 64'd1);
    i_move_valid = 1'b1;
    i_move_col   = col;
    step();
    i_move_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (o_done) begin
        lat = k; ill = o_illegal; wm = o_win_me; wo = o_win_op;
        break;
      end
      step();
    end
    step();
  endtask

  int   lat;
  logic ill, wm, wo;
  int   bad;
  int   seen;
  int   vert_seq [7]  = '{0, 1, 0, 1, 0, 1, 0};
  int   diag_seq [14] = '{0, 2, 1, 0, 2, 1, 2, 1, 3, 2, 3, 3, 3, 3};

  initial begin
    w_rst = 1'b1; i_clear = 1'b0; i_move_valid = 1'b0; i_move_col = 3'd0;
    repeat (2) @(posedge w_clk);
    #1;
    w_rst = 1'b0;

    // Reset state
    check("rst_me",    o_me_field,    64'd0);
    check("rst_op",    o_op_field,    64'd0);
    check("rst_piled", o_piled_array, 64'd0);
    check("rst_ready", o_ready,       64'd1);
    check("rst_turn",  o_turn_me,     64'd1);
    check("rst_flags", {o_win_me, o_win_op, o_draw, o_done, o_illegal}, 64'd0);
    check("rst_count", o_move_count,  64'd0);

    // Single move into column 3
    do_move(3'd3, lat, ill, wm, wo);
    check("one_lat",   lat,           C_LAT);
    check("one_ill",   ill,           64'd0);
    check("one_done1", o_done,        64'd0);
    check("one_ready", o_ready,       64'd1);
    check("one_me",    o_me_field,    64'h8);
    check("one_op",    o_op_field,    64'd0);
    check("one_piled", o_piled_array, 64'h200);
    check("one_turn",  o_turn_me,     64'd0);
    check("one_count", o_move_count,  64'd1);

    // Full column, then overflow and out-of-range column
    pulse_clear();
    check("clr_turn", o_turn_me, 64'd1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      do_move(3'd0, lat, ill, wm, wo);
      if (lat != C_LAT || ill) bad++;
    end
    check("col_moves", bad,           64'd0);
    check("col_me",    o_me_field,    64'h10004001);
    check("col_op",    o_op_field,    64'h800200080);
    check("col_piled", o_piled_array, 64'd6);
    do_move(3'd0, lat, ill, wm, wo);
    check("full_ill",   ill,           64'd1);
    check("full_lat",   lat,           64'd1);
    check("full_me",    o_me_field,    64'h10004001);
    check("full_op",    o_op_field,    64'h800200080);
    check("full_piled", o_piled_array, 64'd6);
    check("full_turn",  o_turn_me,     64'd1);
    check("full_count", o_move_count,  64'd6);
    do_move(3'd7, lat, ill, wm, wo);
    check("c7_ill",   ill,          64'd1);
    check("c7_count", o_move_count, 64'd6);
    check("c7_me",    o_me_field,   64'h10004001);

    // Vertical four for me in column 0
    pulse_clear();
    for (int i = 0; i < 7; i++) do_move(3'(vert_seq[i]), lat, ill, wm, wo);
    check("vert_win_at_done", wm,         C_WIN);
    check("vert_win_op",      o_win_op,   64'd0);
    check("vert_ready",       o_ready,    !C_WIN);
    check("vert_me",          o_me_field, 64'h204081);
    check("vert_op",          o_op_field, 64'h8102);
    check("vert_piled",       o_piled_array, 64'd28);
    check("vert_count",       o_move_count,  64'd7);
`ifdef WIN_CHECK_EN
    i_move_valid = 1'b1; i_move_col = 3'd2;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) i_move_valid = 1'b0;
      step();
      if (o_done) seen++;
    end
    check("over_done",  seen,         64'd0);
    check("over_count", o_move_count, 64'd7);
    check("over_me",    o_me_field,   64'h204081);
    pulse_clear();
    check("over_clr_win",   o_win_me, 64'd0);
    check("over_clr_ready", o_ready,  64'd1);
`endif

    // Diagonal four for the opponent at cells 7, 15, 23, 31
    pulse_clear();
    for (int i = 0; i < 14; i++) do_move(3'(diag_seq[i]), lat, ill, wm, wo);
    check("diag_win_at_done", wo,            C_WIN);
    check("diag_win_me",      o_win_me,      64'd0);
    check("diag_ready",       o_ready,       !C_WIN);
    check("diag_me",          o_me_field,    64'h101060B);
    check("diag_op",          o_op_field,    64'h80828184);
    check("diag_piled",       o_piled_array, 64'hB1A);
    check("diag_count",       o_move_count,  64'd14);

    // Clear while the move is in flight
    pulse_clear();
    i_move_valid = 1'b1; i_move_col = 3'd3;
    step();
    i_move_valid = 1'b0;
`ifdef WIN_CHECK_EN
    step();
    check("mid_board_e1", o_me_field, 64'h8);
`endif
    i_clear = 1'b1;
    seen = 0;
    step();
    i_clear = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (o_done) seen++;
      step();
    end
    check("mid_done",  seen,          64'd0);
    check("mid_me",    o_me_field,    64'd0);
    check("mid_piled", o_piled_array, 64'd0);
    check("mid_count", o_move_count,  64'd0);
    check("mid_ready", o_ready,       64'd1);
    check("mid_turn",  o_turn_me,     64'd1);

    // Move requested in the same cycle as clear is dropped
    i_clear = 1'b1; i_move_valid = 1'b1; i_move_col = 3'd4;
    step();
    i_clear = 1'b0; i_move_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (o_done) seen++;
      step();
    end
    check("drop_done",  seen,         64'd0);
    check("drop_count", o_move_count, 64'd0);
    check("drop_me",    o_me_field,   64'd0);

`ifndef WIN_CHECK_EN
    // Fill the whole board column by column
    pulse_clear();
    bad = 0;
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) begin
        do_move(3'(c), lat, ill, wm, wo);
        if (lat != C_LAT || ill) bad++;
      end
    check("draw_moves", bad,           64'd0);
    check("draw_flag",  o_draw,        64'd1);
    check("draw_wins",  {o_win_me, o_win_op}, 64'd0);
    check("draw_ready", o_ready,       64'd0);
    check("draw_count", o_move_count,  64'd42);
    check("draw_piled", o_piled_array, 64'h1B6DB6);
    check("draw_me",    o_me_field,    64'h7F01FC07F);
    check("draw_op",    o_op_field,    64'h3F80FE03F80);
    pulse_clear();
    check("draw_clr",       o_draw,  64'd0);
    check("draw_clr_ready", o_ready, 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
